// File: rtl/e203_irq_inj_ctrl_pkg.sv
// Shared types and constants for the E203 interrupt-stimulus controller.
// Optional bus-error burst feature is selected by E203_IRQ_INJ_BUSERR_EN.
package e203_irq_inj_ctrl_pkg;

  localparam int unsigned LFSR_W = 32;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {
    G_IDLE  = 3'd0,
    G_ARMED = 3'd1,
    G_RUN   = 3'd2,
    G_DRAIN = 3'd3,
    G_DONE  = 3'd4
  } glb_state_e;

  typedef enum logic [1:0] {
    CH_OFF    = 2'd0,
    CH_WAIT   = 2'd1,
    CH_ASSERT = 2'd2
  } chnl_state_e;

  // One step of the 32-bit Galois LFSR
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/e203_irq_inj_ctrl_if.sv
// Commit-observation and IRQ-drive bundle between the bench and the injector.
// Bus-error side-band signals exist only when E203_IRQ_INJ_BUSERR_EN is defined.
interface e203_irq_inj_ctrl_if #(
  parameter int unsigned CHNL_NUM = 3,
  parameter int unsigned PC_W     = 32
);
  logic                     en_i;
  logic [PC_W-1:0]          start_pc_i;
  logic [PC_W-1:0]          tohost_pc_i;
  logic [CHNL_NUM*PC_W-1:0] ack_pc_i;
  logic                     cmt_valid_i;
  logic [PC_W-1:0]          cmt_pc_i;
  logic [CHNL_NUM-1:0]      irq_o;
  logic [31:0]              tohost_cnt_o;
  logic                     done_o;
`ifdef E203_IRQ_INJ_BUSERR_EN
  logic                     mie_i;
  logic                     bus_read_i;
  logic                     bus_err_o;
`endif

  modport master (
`ifdef E203_IRQ_INJ_BUSERR_EN
    output mie_i, output bus_read_i, input bus_err_o,
`endif
    output en_i, output start_pc_i, output tohost_pc_i, output ack_pc_i,
    output cmt_valid_i, output cmt_pc_i,
    input  irq_o, input tohost_cnt_o, input done_o
  );

  modport slave (
`ifdef E203_IRQ_INJ_BUSERR_EN
    input mie_i, input bus_read_i, output bus_err_o,
`endif
    input  en_i, input start_pc_i, input tohost_pc_i, input ack_pc_i,
    input  cmt_valid_i, input cmt_pc_i,
    output irq_o, output tohost_cnt_o, output done_o
  );

endinterface

// File: rtl/e203_irq_inj_ctrl_chnl.sv
// One IRQ channel: private LFSR, random delay counter and OFF/WAIT/ASSERT FSM.
module e203_irq_inj_ctrl_chnl
  import e203_irq_inj_ctrl_pkg::*;
#(
  parameter int unsigned       DLY_W = 10,
  parameter logic [LFSR_W-1:0] SEED  = 32'hACE1_2345
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_go,     // global ARMED->RUN this cycle
  input  logic i_run,    // global state is RUN
  input  logic i_ack,    // handler-exit PC of this channel committed
  output logic o_irq,
  output logic o_off_c
);

  chnl_state_e       r_state;
  chnl_state_e       w_state_nxt;
  logic [DLY_W-1:0]  r_dly;
  logic [DLY_W-1:0]  w_dly_nxt;
  logic [DLY_W-1:0]  w_dly_load;
  logic [LFSR_W-1:0] r_lfsr;
  logic              r_irq;

  // Forcing bit 0 keeps the delay non-zero
  assign w_dly_load = r_lfsr[DLY_W-1:0] | DLY_W'(1);

  // LFSR free-runs from reset independent of channel state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_lfsr <= SEED;
    else        r_lfsr <= lfsr_step(r_lfsr);
  end

  // Channel state, delay counter and registered IRQ
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CH_OFF;
      r_dly   <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dly   <= w_dly_nxt;
      r_irq   <= (w_state_nxt == CH_ASSERT);
    end
  end

  // Next state: leaving RUN cancels a pending wait but never cuts an asserted IRQ
  always_comb begin
    w_state_nxt = r_state;
    w_dly_nxt   = r_dly;
    unique case (r_state)
      CH_OFF: begin
        if (i_go) begin
          w_state_nxt = CH_WAIT;
          w_dly_nxt   = w_dly_load;
        end
      end
      CH_WAIT: begin
        if (!i_run) begin
          w_state_nxt = CH_OFF;
        end else if (r_dly == DLY_W'(1)) begin
          w_state_nxt = CH_ASSERT;
        end else begin
          w_dly_nxt = r_dly - DLY_W'(1);
        end
      end
      CH_ASSERT: begin
        if (i_ack) begin
          if (i_run) begin
            w_state_nxt = CH_WAIT;
            w_dly_nxt   = w_dly_load;
          end else begin
            w_state_nxt = CH_OFF;
          end
        end
      end
      default: w_state_nxt = CH_OFF;
    endcase
  end

  assign o_irq   = r_irq;
  assign o_off_c = (r_state == CH_OFF);

endmodule

// File: rtl/e203_irq_inj_ctrl.sv
// E203 interrupt-stimulus controller: global sequencing FSM, tohost commit
// counter and CHNL_NUM independent IRQ channels.
// Define E203_IRQ_INJ_BUSERR_EN to add the bus-error burst generator.
module e203_irq_inj_ctrl
  import e203_irq_inj_ctrl_pkg::*;
#(
  parameter int unsigned       CHNL_NUM  = 3,
  parameter int unsigned       PC_W      = 32,
  parameter int unsigned       DLY_W     = 10,
  parameter int unsigned       STOP_CNT  = 32,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 32'hACE1_2345
`ifdef E203_IRQ_INJ_BUSERR_EN
  ,
  parameter int unsigned       BERR_W    = 8
`endif
) (
  input logic                   clk,
  input logic                   rst_n,
  e203_irq_inj_ctrl_if.slave    bus
);

  glb_state_e          r_state;
  glb_state_e          w_state_nxt;
  logic [31:0]         r_tohost_cnt;
  logic                r_done;
  logic                w_start_hit;
  logic                w_tohost_hit;
  logic                w_go;
  logic                w_run;
  logic [CHNL_NUM-1:0] w_ack_hit;
  logic [CHNL_NUM-1:0] w_irq;
  logic [CHNL_NUM-1:0] w_off;

  assign w_start_hit  = bus.cmt_valid_i && (bus.cmt_pc_i == bus.start_pc_i);
  assign w_tohost_hit = bus.cmt_valid_i && (bus.cmt_pc_i == bus.tohost_pc_i);
  assign w_go         = (r_state == G_ARMED) && w_start_hit;
  assign w_run        = (r_state == G_RUN);

  // Global state and registered done flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= G_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (w_state_nxt == G_DONE);
    end
  end

  // Global next state, one transition per cycle
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      G_IDLE:  if (bus.en_i) w_state_nxt = G_ARMED;
      G_ARMED: if (w_start_hit) w_state_nxt = G_RUN;
      G_RUN: begin
        if ((r_tohost_cnt > 32'(STOP_CNT)) || !bus.en_i) w_state_nxt = G_DRAIN;
      end
      G_DRAIN: if (&w_off) w_state_nxt = G_DONE;
      G_DONE:  w_state_nxt = G_DONE;
      default: w_state_nxt = G_IDLE;
    endcase
  end

  // Saturating tohost commit counter, active in every state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tohost_cnt <= '0;
    end else if (w_tohost_hit && (r_tohost_cnt != '1)) begin
      r_tohost_cnt <= r_tohost_cnt + 32'd1;
    end
  end

  // Per-channel ack decode and channel instances
  for (genvar gi = 0; gi < CHNL_NUM; gi++) begin : g_chnl
    assign w_ack_hit[gi] = bus.cmt_valid_i &&
                           (bus.cmt_pc_i == bus.ack_pc_i[gi*PC_W +: PC_W]);

    e203_irq_inj_ctrl_chnl #(
      .DLY_W (DLY_W),
      .SEED  (LFSR_SEED ^ 32'(gi + 1))
    ) u_chnl (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_go    (w_go),
      .i_run   (w_run),
      .i_ack   (w_ack_hit[gi]),
      .o_irq   (w_irq[gi]),
      .o_off_c (w_off[gi])
    );
  end

  assign bus.irq_o        = w_irq;
  assign bus.tohost_cnt_o = r_tohost_cnt;
  assign bus.done_o       = r_done;

`ifdef E203_IRQ_INJ_BUSERR_EN
  logic [LFSR_W-1:0] r_berr_lfsr;
  logic [BERR_W-1:0] r_berr_cnt;
  logic [BERR_W-1:0] w_berr_load;
  logic              r_berr_hi;

  assign w_berr_load = r_berr_lfsr[BERR_W-1:0] | BERR_W'(1);

  // Alternating low/high burst windows, parked low outside RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_berr_lfsr <= LFSR_SEED;
      r_berr_cnt  <= '0;
      r_berr_hi   <= 1'b0;
    end else begin
      r_berr_lfsr <= lfsr_step(r_berr_lfsr);
      if (!w_run) begin
        r_berr_hi  <= 1'b0;
        r_berr_cnt <= w_berr_load;
      end else if (r_berr_cnt <= BERR_W'(1)) begin
        r_berr_hi  <= ~r_berr_hi;
        r_berr_cnt <= w_berr_load;
      end else begin
        r_berr_cnt <= r_berr_cnt - BERR_W'(1);
      end
    end
  end

  assign bus.bus_err_o = r_berr_hi & bus.mie_i & bus.bus_read_i & w_run;
`endif

endmodule
